// File: rtl/seven_seg_pkg.sv
// Shared definitions for the two-digit seven-segment display interface:
// active-low glyph set, line polarities, digit indices and capture types.
package seven_seg_pkg;

    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    // Segment and enable lines are both active-low.
    localparam logic       SEG_ON    = 1'b0;
    localparam logic       SEG_OFF   = 1'b1;
    localparam logic [1:0] EN_SEL_LO = 2'b10;
    localparam logic [1:0] EN_SEL_HI = 2'b01;
    localparam logic [1:0] EN_BLANK  = 2'b11;

    localparam logic DIGIT_LO = 1'b0;
    localparam logic DIGIT_HI = 1'b1;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [3:0] hi_nib;
        logic [3:0] lo_nib;
        logic       hi_dp;
        logic       lo_dp;
    } frame_t;

    function automatic logic [7:0] glyph_of(input logic [3:0] nib);
        case (nib)
            4'h0:    glyph_of = GLYPH_0;
            4'h1:    glyph_of = GLYPH_1;
            4'h2:    glyph_of = GLYPH_2;
            4'h3:    glyph_of = GLYPH_3;
            4'h4:    glyph_of = GLYPH_4;
            4'h5:    glyph_of = GLYPH_5;
            4'h6:    glyph_of = GLYPH_6;
            4'h7:    glyph_of = GLYPH_7;
            4'h8:    glyph_of = GLYPH_8;
            4'h9:    glyph_of = GLYPH_9;
            4'hA:    glyph_of = GLYPH_A;
            4'hB:    glyph_of = GLYPH_B;
            4'hC:    glyph_of = GLYPH_C;
            4'hD:    glyph_of = GLYPH_D;
            4'hE:    glyph_of = GLYPH_E;
            default: glyph_of = GLYPH_F;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_glyph_decode.sv
// Combinational reverse lookup of a 7-segment pattern (dp excluded) to a
// hex nibble; ok is low when the pattern is not one of the sixteen glyphs.
module seven_seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       ok,
    output logic [3:0] nibble
);

    logic [7:0] glyph;

    // dp is forced off on both sides so only segments a..g take part.
    always_comb begin
        ok     = 1'b0;
        nibble = 4'h0;
        glyph  = 8'h00;
        for (int i = 0; i < 16; i++) begin
            glyph = glyph_of(4'(i));
            if (!ok && ((glyph | 8'h80) == {1'b1, pattern})) begin
                ok     = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// Receive end of the multiplexed two-digit display: settles each digit,
// assembles frames, and publishes a value after repeated identical frames.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int MATCH_FRAMES   = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] segments,
    input  logic [1:0] enable,
    output logic [7:0] value,
    output logic [1:0] dp,
    output logic       valid,
    output logic       locked,
    output logic       glyph_err,
    output logic       stale
);

    localparam int              TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      SETTLE_N     = 8'(SETTLE_CYCLES);
    localparam logic [3:0]      MATCH_N      = 4'(MATCH_FRAMES);
    localparam logic [TW-1:0]   TIMEOUT_N    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]  r_seg;
    logic [1:0]  r_en;
    logic        sel_any;
    logic        sel_digit;

    scan_state_t state;
    scan_state_t state_n;
    logic [7:0]  settle_cnt;
    logic [7:0]  settle_n;
    logic        cap_digit;
    logic        cap_digit_n;
    logic [7:0]  cap_pat;
    logic [7:0]  cap_pat_n;
    logic        restart;
    logic        latch;

    logic        dec_ok;
    logic [3:0]  dec_nib;
    logic        lat_dp;

    frame_t      part;
    logic        have_lo;
    logic        have_hi;
    frame_t      new_frame;
    frame_t      prev_frame;
    logic        prev_ok;
    logic        frame_done;
    logic        same_frame;
    logic [3:0]  match_cnt;
    logic [3:0]  match_next;
    logic        publish;
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg <= {8{SEG_OFF}};
            r_en  <= EN_BLANK;
        end else begin
            r_seg <= segments;
            r_en  <= enable;
        end
    end

    // Blank (both high) and illegal (both low) enables select no digit.
    always_comb begin
        sel_any   = 1'b0;
        sel_digit = DIGIT_LO;
        if (r_en == EN_SEL_LO) begin
            sel_any = 1'b1;
        end else if (r_en == EN_SEL_HI) begin
            sel_any   = 1'b1;
            sel_digit = DIGIT_HI;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_SCAN;
            settle_cnt <= 8'd0;
            cap_digit  <= DIGIT_LO;
            cap_pat    <= {8{SEG_OFF}};
        end else begin
            state      <= state_n;
            settle_cnt <= settle_n;
            cap_digit  <= cap_digit_n;
            cap_pat    <= cap_pat_n;
        end
    end

    // Any leave from SETTLE or HOLD that still sees a selected digit starts
    // a fresh capture in that same cycle, so no cycle of the dwell is lost.
    always_comb begin
        state_n     = state;
        settle_n    = settle_cnt;
        cap_digit_n = cap_digit;
        cap_pat_n   = cap_pat;
        restart     = 1'b0;
        latch       = 1'b0;
        case (state)
            ST_SCAN: begin
                restart = sel_any;
            end
            ST_SETTLE: begin
                if (!sel_any || (sel_digit != cap_digit) || (r_seg != cap_pat)) begin
                    restart = sel_any;
                    state_n = ST_SCAN;
                end else if (settle_cnt >= SETTLE_N) begin
                    latch   = 1'b1;
                    state_n = ST_HOLD;
                end else begin
                    settle_n = settle_cnt + 8'd1;
                end
            end
            ST_HOLD: begin
                if (!sel_any || (sel_digit != cap_digit)) begin
                    restart = sel_any;
                    state_n = ST_SCAN;
                end
            end
            default: begin
                state_n = ST_SCAN;
            end
        endcase
        if (restart) begin
            state_n     = ST_SETTLE;
            settle_n    = 8'd1;
            cap_digit_n = sel_digit;
            cap_pat_n   = r_seg;
        end
    end

    seven_seg_glyph_decode u_decode (
        .pattern (cap_pat[6:0]),
        .ok      (dec_ok),
        .nibble  (dec_nib)
    );

    assign lat_dp = (cap_pat[7] == SEG_ON);

    always_comb begin
        new_frame = part;
        if (cap_digit == DIGIT_HI) begin
            new_frame.hi_nib = dec_nib;
            new_frame.hi_dp  = lat_dp;
        end else begin
            new_frame.lo_nib = dec_nib;
            new_frame.lo_dp  = lat_dp;
        end
    end

    assign frame_done = latch && dec_ok && ((cap_digit == DIGIT_HI) ? have_lo : have_hi);
    assign same_frame = prev_ok && (new_frame == prev_frame);

    always_comb begin
        match_next = 4'd1;
        if (same_frame) begin
            match_next = (match_cnt >= MATCH_N) ? match_cnt : match_cnt + 4'd1;
        end
    end

    // Publish only on the frame that brings the run up to the threshold.
    assign publish = frame_done && (match_next == MATCH_N)
                     && !(same_frame && (match_cnt == MATCH_N));

    always_ff @(posedge clk) begin
        if (rst) begin
            part       <= '0;
            have_lo    <= 1'b0;
            have_hi    <= 1'b0;
            prev_frame <= '0;
            prev_ok    <= 1'b0;
            match_cnt  <= 4'd0;
            tmo_cnt    <= '0;
            value      <= 8'h00;
            dp         <= 2'b00;
            valid      <= 1'b0;
            locked     <= 1'b0;
            glyph_err  <= 1'b0;
            stale      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            glyph_err <= 1'b0;
            if (latch) begin
                tmo_cnt <= '0;
                stale   <= 1'b0;
                if (!dec_ok) begin
                    glyph_err <= 1'b1;
                    have_lo   <= 1'b0;
                    have_hi   <= 1'b0;
                    match_cnt <= 4'd0;
                    locked    <= 1'b0;
                end else if (frame_done) begin
                    have_lo    <= 1'b0;
                    have_hi    <= 1'b0;
                    prev_frame <= new_frame;
                    prev_ok    <= 1'b1;
                    match_cnt  <= match_next;
                    if (!same_frame) begin
                        locked <= 1'b0;
                    end
                    if (publish) begin
                        value  <= {new_frame.hi_nib, new_frame.lo_nib};
                        dp     <= {new_frame.hi_dp, new_frame.lo_dp};
                        valid  <= 1'b1;
                        locked <= 1'b1;
                    end
                end else begin
                    part <= new_frame;
                    if (cap_digit == DIGIT_HI) begin
                        have_hi <= 1'b1;
                    end else begin
                        have_lo <= 1'b1;
                    end
                end
            end else if (tmo_cnt != TIMEOUT_N) begin
                tmo_cnt <= tmo_cnt + TW'(1);
                // A stalled scan forces a full re-acquisition afterwards.
                if (tmo_cnt == TIMEOUT_LAST) begin
                    stale     <= 1'b1;
                    locked    <= 1'b0;
                    match_cnt <= 4'd0;
                    prev_ok   <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed and randomized scan sequences for seven_seg_capture, checked
// against a segment-level behavioural model of the capture rules.
module tb_seven_seg_capture;

    localparam int S = 4;
    localparam int M = 2;
    localparam int T = 65535;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] segments;
    logic [1:0] enable;
    logic [7:0] value;
    logic [1:0] dp;
    logic       valid;
    logic       locked;
    logic       glyph_err;
    logic       stale;

    int n_vec = 0;
    int n_bad = 0;
    int valid_seen = 0;
    int glyph_seen = 0;

    logic [7:0] hex_glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [7:0] pool [4] = '{8'h87, 8'h12, 8'hA5, 8'h3C};

    int         m_held;
    bit         m_have [2];
    logic [3:0] m_nib [2];
    logic       m_dpb [2];
    logic [9:0] m_prev;
    bit         m_prev_ok;
    int         m_match;
    logic [7:0] m_value;
    logic [1:0] m_dp;
    logic       m_locked;
    logic       m_stale;
    int         m_valid_cnt;
    int         m_glyph_cnt;
    int         m_idle;

    always #5 clk = ~clk;

    seven_seg_capture #(
        .SETTLE_CYCLES  (S),
        .MATCH_FRAMES   (M),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .segments  (segments),
        .enable    (enable),
        .value     (value),
        .dp        (dp),
        .valid     (valid),
        .locked    (locked),
        .glyph_err (glyph_err),
        .stale     (stale)
    );

    always @(negedge clk) begin
        if (valid === 1'b1) valid_seen++;
        if (glyph_err === 1'b1) glyph_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int decode_glyph(input logic [7:0] p);
        for (int i = 0; i < 16; i++) begin
            if (hex_glyph[i][6:0] == p[6:0]) return i;
        end
        return -1;
    endfunction

    function automatic logic [7:0] pat_of(input logic [3:0] n, input logic lit);
        logic [7:0] g;
        g = hex_glyph[n];
        if (lit) g[7] = 1'b0;
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_held = -1;
        m_have[0] = 0;
        m_have[1] = 0;
        m_prev = '0;
        m_prev_ok = 0;
        m_match = 0;
        m_value = 8'h00;
        m_dp = 2'b00;
        m_locked = 1'b0;
        m_stale = 1'b0;
        m_idle = 0;
    endtask

    task automatic model_latch(input int d, input logic [7:0] pat);
        int n;
        logic [9:0] fr;
        bit reached;
        m_idle = 0;
        m_stale = 1'b0;
        n = decode_glyph(pat);
        if (n < 0) begin
            m_glyph_cnt++;
            m_have[0] = 0;
            m_have[1] = 0;
            m_match = 0;
            m_locked = 1'b0;
            return;
        end
        m_nib[d] = 4'(n);
        m_dpb[d] = ~pat[7];
        m_have[d] = 1;
        if (m_have[0] && m_have[1]) begin
            fr = {m_nib[1], m_nib[0], m_dpb[1], m_dpb[0]};
            reached = 0;
            if (m_prev_ok && fr == m_prev) begin
                if (m_match < M) begin
                    m_match++;
                    reached = (m_match == M);
                end
            end else begin
                m_match = 1;
                m_locked = 1'b0;
                reached = (M == 1);
            end
            m_prev = fr;
            m_prev_ok = 1;
            m_have[0] = 0;
            m_have[1] = 0;
            if (reached) begin
                m_value = {m_nib[1], m_nib[0]};
                m_dp = {m_dpb[1], m_dpb[0]};
                m_locked = 1'b1;
                m_valid_cnt++;
            end
        end
    endtask

    // A constant (enable, pattern) run latches when it lasts S+1 cycles,
    // unless the same digit was already latched and never deselected.
    task automatic model_seg(input logic [1:0] en, input logic [7:0] pat, input int len);
        int d;
        d = (en == 2'b10) ? 0 : (en == 2'b01) ? 1 : -1;
        if (d < 0) begin
            m_held = -1;
            m_idle += len;
            if (!m_stale && m_idle >= T) begin
                m_stale = 1'b1;
                m_locked = 1'b0;
                m_match = 0;
                m_prev_ok = 0;
            end
        end else if (m_held == d) begin
            m_idle += len;
        end else if (len >= S + 1) begin
            model_latch(d, pat);
            m_held = d;
            m_idle = len - (S + 1);
        end else begin
            m_held = -1;
            m_idle += len;
        end
    endtask

    task automatic seg(input logic [1:0] en, input logic [7:0] pat, input int len);
        segments = pat;
        enable = en;
        model_seg(en, pat, len);
        repeat (len) tick();
    endtask

    task automatic blank(input int len);
        seg(2'b11, 8'hFF, len);
    endtask

    task automatic show_digit(input int d, input logic [7:0] pat, input int dwell);
        seg((d == 1) ? 2'b01 : 2'b10, pat, dwell);
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s.value", tag), 32'(value), 32'(m_value));
        check($sformatf("%s.dp", tag), 32'(dp), 32'(m_dp));
        check($sformatf("%s.locked", tag), 32'(locked), 32'(m_locked));
        check($sformatf("%s.stale", tag), 32'(stale), 32'(m_stale));
        check($sformatf("%s.valid_pulses", tag), 32'(valid_seen), 32'(m_valid_cnt));
        check($sformatf("%s.glyph_pulses", tag), 32'(glyph_seen), 32'(m_glyph_cnt));
    endtask

    task automatic frame(input logic [7:0] v, input logic [1:0] dpv, input int dwell, input string tag);
        show_digit(1, pat_of(v[7:4], dpv[1]), dwell);
        blank(2);
        show_digit(0, pat_of(v[3:0], dpv[0]), dwell);
        blank(3);
        check_all(tag);
    endtask

    task automatic rand_digit(input int d, input logic [3:0] nib, input logic lit);
        logic [7:0] main_pat;
        logic [7:0] other;
        logic [1:0] en;
        en = (d == 1) ? 2'b01 : 2'b10;
        main_pat = pat_of(nib, lit);
        if ($urandom_range(0, 14) == 0) main_pat = 8'hFF;
        if ($urandom_range(0, 3) == 0) begin
            other = pat_of(4'(nib + 4'($urandom_range(1, 15))), lit);
            seg(en, other, $urandom_range(1, S + 1));
        end
        seg(en, main_pat, $urandom_range(S - 1, S + 4));
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s.value", tag), 32'(value), 32'h00);
        check($sformatf("%s.dp", tag), 32'(dp), 32'h0);
        check($sformatf("%s.valid", tag), 32'(valid), 32'h0);
        check($sformatf("%s.locked", tag), 32'(locked), 32'h0);
        check($sformatf("%s.glyph_err", tag), 32'(glyph_err), 32'h0);
        check($sformatf("%s.stale", tag), 32'(stale), 32'h0);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] last_v;
        logic [1:0] dpv;
        int order;

        m_valid_cnt = 0;
        m_glyph_cnt = 0;
        model_reset();
        rst = 1'b1;
        segments = 8'hFF;
        enable = 2'b11;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // 0x87 twice: publishes on the second frame only.
        frame(8'h87, 2'b00, 8, "scan87.f1");
        check("scan87.f1.no_valid", 32'(valid_seen), 32'd0);
        frame(8'h87, 2'b00, 8, "scan87.f2");
        check("scan87.value", 32'(value), 32'h87);
        check("scan87.locked", 32'(locked), 32'h1);
        check("scan87.valid_once", 32'(valid_seen), 32'd1);
        frame(8'h87, 2'b00, 8, "scan87.f3");
        check("scan87.no_repulse", 32'(valid_seen), 32'd1);

        // Ghost 8 shows for two cycles before the real 0 glyph.
        for (int f = 0; f < 2; f++) begin
            seg(2'b01, 8'h80, 2);
            seg(2'b01, 8'hC0, 6);
            blank(2);
            show_digit(0, 8'hF8, 8);
            blank(3);
            check_all($sformatf("ghost.f%0d", f));
        end
        check("ghost.value", 32'(value), 32'h07);

        // Blank pattern on an enabled digit is not a glyph.
        show_digit(1, 8'h80, 8);
        blank(2);
        show_digit(0, 8'hFF, 8);
        blank(3);
        check_all("badglyph");
        check("badglyph.locked", 32'(locked), 32'h0);
        check("badglyph.value_kept", 32'(value), 32'h07);

        for (int f = 0; f < 4; f++) begin
            frame((f % 2 == 0) ? 8'h87 : 8'h12, 2'b00, 8, $sformatf("alt.f%0d", f));
        end
        check("alt.never_valid", 32'(valid_seen), 32'd2);

        // Short dwell of exactly S cycles never latches; S+1 does.
        frame(8'h3C, 2'b10, S, "dwell_short");
        frame(8'h3C, 2'b10, S + 1, "dwell_min.f1");
        frame(8'h3C, 2'b10, S + 1, "dwell_min.f2");
        check("dwell_min.dp", 32'(dp), 32'h2);

        last_v = 8'h87;
        for (int f = 0; f < 40; f++) begin
            if (f > 0 && $urandom_range(0, 1) == 0) v = last_v;
            else v = pool[$urandom_range(0, 3)];
            dpv = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            last_v = v;
            order = $urandom_range(0, 1);
            if (order == 1) begin
                rand_digit(1, v[7:4], dpv[1]);
                blank($urandom_range(1, 3));
                rand_digit(0, v[3:0], dpv[0]);
            end else begin
                rand_digit(0, v[3:0], dpv[0]);
                blank($urandom_range(1, 3));
                rand_digit(1, v[7:4], dpv[1]);
            end
            blank(3);
            check_all($sformatf("rand.f%0d", f));
        end

        // Reset after the high digit latched discards the partial frame.
        frame(8'h87, 2'b00, 8, "prerst.f1");
        frame(8'h87, 2'b00, 8, "prerst.f2");
        show_digit(1, 8'h80, 8);
        blank(2);
        rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        model_reset();
        rst = 1'b0;
        blank(2);
        frame(8'h87, 2'b00, 8, "postrst.f1");
        check("postrst.f1.value", 32'(value), 32'h00);
        frame(8'h87, 2'b00, 8, "postrst.f2");
        check("postrst.f2.value", 32'(value), 32'h87);

        blank(65000);
        check_all("stall.before");
        blank(700);
        check_all("stall.after");
        check("stall.stale", 32'(stale), 32'h1);
        check("stall.locked", 32'(locked), 32'h0);
        show_digit(1, 8'h80, 8);
        blank(3);
        check("resume.stale_cleared", 32'(stale), 32'(m_stale));
        show_digit(0, 8'hF8, 8);
        blank(3);
        check_all("resume.f1");
        frame(8'h87, 2'b00, 8, "resume.f2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Observes the multiplexed two-digit seven-segment drive (segments + per-digit enable) and reconstructs the displayed 8-bit hex value. It is the receive end of the display interface and is used for on-chip loopback self-test of the display driver and as a bench monitor. It sits beside the display driver on the same clock and taps its outputs. It rejects transition ghosting, requires repeated identical scan frames before publishing, and flags unknown glyphs and a stalled scan.

## Interface
- SETTLE_CYCLES, 4: consecutive cycles a digit's enable and segment pattern must hold unchanged before the digit is latched (1..255).
- MATCH_FRAMES, 2: consecutive identical complete frames required before `value` updates (1..15).
- TIMEOUT_CYCLES, 65535: cycles with no digit latched before `stale` asserts (≥ 2·SETTLE_CYCLES).
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- segments  in  8  observed segment lines, active-low; [0]=a … [6]=g, [7]=dp.
- enable  in  2  observed digit enables, active-low; [0]=low nibble digit, [1]=high nibble digit.
- value  out  8  last published value, {high digit, low digit}.
- dp  out  2  decimal-point state per digit of the last published frame (1 = lit).
- valid  out  1  one-cycle pulse when `value`/`dp` update.
- locked  out  1  level; published value is current (cleared by mismatch, glyph error or timeout).
- glyph_err  out  1  one-cycle pulse when a latched pattern is not a hex glyph.
- stale  out  1  level; no digit latched for TIMEOUT_CYCLES.

## Operation
- Inputs registered once (r_seg, r_en) before all logic.
- Digit select: r_en = 2'b10 selects digit 0, 2'b01 selects digit 1; 2'b11 (blank) and 2'b00 (illegal) select none.
- FSM per observed digit:
  - SCAN: wait for a selected digit; load settle counter = 1, capture {digit, pattern} -> SETTLE.
  - SETTLE: if select or pattern differs from capture -> restart SETTLE with new capture (or SCAN if none selected); when counter reaches SETTLE_CYCLES -> latch digit -> HOLD.
  - HOLD: wait until select differs from the latched digit -> SCAN (re-evaluated in the same cycle).
- Latch: pattern[6:0] decoded to nibble 0–F; dp = ~pattern[7]. Undecodable -> glyph_err pulse, discard partial frame, clear match count and locked.
- Frame: complete when both digits latched since the last frame start, in either order. Relatching the same digit before the other overwrites it.
- Match: frame equal (both nibbles and dp) to previous frame -> match_cnt += 1 (saturating), else match_cnt = 1 and locked = 0. When match_cnt reaches MATCH_FRAMES: publish value/dp, pulse valid, set locked. Further identical frames do not re-pulse valid.
- Timeout: counter resets on every latch; at TIMEOUT_CYCLES sets stale and clears locked; stale clears on the next latch.
- Reset: value = 8'h00, dp = 2'b00, valid = 0, locked = 0, glyph_err = 0, stale = 0; FSM -> SCAN, all counters and partial frame cleared. Reset mid-frame discards the frame.

## Timing
- Input register: 1 cycle.
- Digit latch occurs SETTLE_CYCLES cycles after the first registered cycle of a stable digit.
- valid asserts the cycle after the latch that completes the MATCH_FRAMES-th matching frame.
- glyph_err asserts the cycle after the offending latch.
- Minimum enable dwell the block accepts: SETTLE_CYCLES + 1 cycles; shorter dwells never latch.

## Structure
- Package seven_seg_pkg: active-low glyph constants GLYPH_0..GLYPH_F (e.g. 8 = 8'h80, 7 = 8'hF8, 0 = 8'hC0), polarity constants, digit-index constants. These are shared with the display driver.
- Sub-module seven_seg_glyph_decode: combinational 7-bit pattern -> {ok, nibble}.
- Top holds the input register, FSM, settle/match/timeout counters and publish register.

## Test plan
- Scan 0x87 (digit1 = 8'h80, digit0 = 8'hF8, 8-cycle dwell, 2'b11 blanking between digits) for 2 frames -> valid pulse once, value = 8'h87, locked = 1, dp = 2'b00.
- Pattern toggles mid-dwell (8'h80 -> 8'hC0 at cycle 2 of SETTLE, SETTLE_CYCLES = 4) -> digit latches 0, no ghost 8; value 0x07 after 2 frames.
- Digit0 = 8'hFF (blank pattern) while enabled -> glyph_err pulse, locked = 0, value unchanged.
- Alternate frames 0x87 / 0x12 -> valid never pulses, locked stays 0.
- Enables held 2'b11 for 65535 cycles after lock -> stale = 1, locked = 0; resume 0x87 -> stale clears on the first latch.
- rst pulse mid-frame -> all outputs at reset values next cycle; the first complete frame after reset does not publish until MATCH_FRAMES frames have matched.
